// File: rtl/ms_mouse_serial_rx_if.sv
// ---------------------------------------------------------------------------
// ms_mouse_serial_rx_if
//  Bundles the serial RD line and the mouse-emulation outputs of the Microsoft
//  serial mouse receiver.
//  Signals:
//   rxd        serial RD line, idle high, asynchronous to clk
//   ms_x       signed X delta of the last packet
//   ms_y       signed Y delta, host convention (negated packet Y)
//   ms_b       {middle, right, left} buttons
//   ms_upd     toggles once per published packet
//   ident      1-cycle pulse, lone 'M' identification char seen
//   frame_err  1-cycle pulse, stop bit sampled low
//  Modports:
//   slave   the receiver (consumes rxd, drives the mouse outputs)
//   master  the link/consumer side (drives rxd, observes the outputs)
// ---------------------------------------------------------------------------
interface ms_mouse_serial_rx_if;
  logic       rxd;
  logic [7:0] ms_x;
  logic [7:0] ms_y;
  logic [2:0] ms_b;
  logic       ms_upd;
  logic       ident;
  logic       frame_err;

  modport slave (
    input  rxd,
    output ms_x, ms_y, ms_b, ms_upd, ident, frame_err
  );

  modport master (
    output rxd,
    input  ms_x, ms_y, ms_b, ms_upd, ident, frame_err
  );
endinterface

// File: rtl/ms_mouse_serial_rx.sv
// ---------------------------------------------------------------------------
// ms_mouse_serial_rx
//  Receiving end of the Microsoft serial mouse link. Samples the RD line,
//  deframes 7-bit characters, assembles 3-byte MS packets and republishes them
//  on the ms_x/ms_y/ms_b/ms_upd toggle interface. Reports the lone 'M'
//  identification character on ident.
//  Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   bus    ms_mouse_serial_rx_if.slave (rxd in; ms_x, ms_y, ms_b, ms_upd,
//          ident, frame_err out)
//  Parameters:
//   CLKFREQ  clock frequency in Hz
//   BAUD     serial bit rate
//   GAP_MS   inter-byte timeout in ms
//  Configuration macro:
//   MS_MOUSE_3BTN_EN  enables the Logitech 4th byte (middle button).
// ---------------------------------------------------------------------------
module ms_mouse_serial_rx #(
  parameter int CLKFREQ = 50_000_000,
  parameter int BAUD    = 1_200,
  parameter int GAP_MS  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ms_mouse_serial_rx_if.slave   bus
);

  localparam int BITPER  = CLKFREQ / BAUD;
  localparam int HALFBIT = BITPER / 2;
  localparam int TMO     = (CLKFREQ / 1000) * GAP_MS;
  localparam int TW      = $clog2(BITPER + 1);
  localparam int OW      = $clog2(TMO + 1);

  // -------------------------------------------------------------------------
  // Input synchroniser and start-edge detection
  // -------------------------------------------------------------------------
  logic       r_sync1, r_sync2, r_hist;
  logic [1:0] r_flush;
  logic       r_armed;
  logic       w_fall;

  // The sync chain is preset high, so a line held low at reset release would
  // look like a falling edge. Edge detection is armed only once a genuine
  // high level has travelled through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
      if (r_flush[1] && r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_fall = r_armed & r_hist & ~r_sync2;

  // -------------------------------------------------------------------------
  // Character receiver FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK
  } rx_state_t;

  rx_state_t     r_rx, w_rx_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_ld;
  logic          w_tick;
  logic          w_shift_en;
  logic          w_stop_ok;
  logic          w_stop_bad;
  logic [2:0]    r_nbit;
  logic [6:0]    r_shift;
  logic          r_byte_vld;
  logic [6:0]    r_byte;
  logic          r_frame_err;

  assign w_tick = (r_tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx <= RX_IDLE;
    else        r_rx <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt   = r_rx;
    w_tmr_ld   = 1'b0;
    w_tmr_val  = '0;
    w_shift_en = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_rx)
      RX_IDLE: begin
        if (w_fall) begin
          w_rx_nxt  = RX_START;
          w_tmr_ld  = 1'b1;
          w_tmr_val = TW'(HALFBIT - 1);
        end
      end
      RX_START: begin
        // Mid-start sample: a high line means the fall was only a glitch.
        if (w_tick) begin
          if (r_sync2) begin
            w_rx_nxt = RX_IDLE;
          end else begin
            w_rx_nxt  = RX_DATA;
            w_tmr_ld  = 1'b1;
            w_tmr_val = TW'(BITPER - 1);
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_tmr_ld   = 1'b1;
          w_tmr_val  = TW'(BITPER - 1);
          if (r_nbit == 3'd6) w_rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_stop_ok = 1'b1;
            w_rx_nxt  = RX_IDLE;
          end else begin
            w_stop_bad = 1'b1;
            w_rx_nxt   = RX_BRK;
          end
        end
      end
      RX_BRK: begin
        // Hold off until the line returns high so a break or a corrupted
        // frame cannot spawn a false start bit.
        if (r_sync2) w_rx_nxt = RX_IDLE;
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr       <= '0;
      r_nbit      <= 3'd0;
      r_shift     <= 7'd0;
      r_byte_vld  <= 1'b0;
      r_byte      <= 7'd0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_tmr_ld)          r_tmr <= w_tmr_val;
      else if (r_tmr != '0)  r_tmr <= r_tmr - TW'(1);

      if (r_rx == RX_IDLE)   r_nbit <= 3'd0;
      else if (w_shift_en)   r_nbit <= r_nbit + 3'd1;

      // LSB first: new bits enter at the top and walk down.
      if (w_shift_en) r_shift <= {r_sync2, r_shift[6:1]};

      r_byte_vld  <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      if (w_stop_ok) r_byte <= r_shift;
    end
  end

  // -------------------------------------------------------------------------
  // Packet assembler FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    AS_B1, AS_B2, AS_B3, AS_B4
  } as_state_t;

  as_state_t     r_as, w_as_nxt;
  logic [OW-1:0] r_tmo;
  logic [6:0]    r_b1;
  logic [5:0]    r_b2;
  logic          w_ld1, w_ld2, w_pub, w_pub4, w_ident, w_expire;
  logic [7:0]    r_x, r_y;
  logic [1:0]    r_btn;
  logic          r_upd;
  logic          r_ident;
  logic          w_btn2;
  logic [7:0]    w_dx, w_dy;

  // A byte arriving on the expiry cycle takes priority: it reloads the
  // timer instead of discarding the partial packet.
  assign w_expire = (r_as != AS_B1) && (r_tmo == '0) && !r_byte_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_as <= AS_B1;
    else        r_as <= w_as_nxt;
  end

  always_comb begin
    w_as_nxt = r_as;
    w_ld1    = 1'b0;
    w_ld2    = 1'b0;
    w_pub    = 1'b0;
    w_pub4   = 1'b0;
    w_ident  = 1'b0;
    if (r_frame_err) begin
      w_as_nxt = AS_B1;
    end else if (r_byte_vld) begin
      if (r_byte[6]) begin
        // Header char always resyncs, dropping any partial packet.
        w_ld1    = 1'b1;
        w_as_nxt = AS_B2;
      end else begin
        case (r_as)
          AS_B2: begin
            w_ld2    = 1'b1;
            w_as_nxt = AS_B3;
          end
          AS_B3: begin
            w_pub    = 1'b1;
`ifdef MS_MOUSE_3BTN_EN
            w_as_nxt = AS_B4;
`else
            w_as_nxt = AS_B1;
`endif
          end
`ifdef MS_MOUSE_3BTN_EN
          AS_B4: begin
            w_pub4   = 1'b1;
            w_as_nxt = AS_B1;
          end
`endif
          default: w_as_nxt = r_as;
        endcase
      end
    end else if (w_expire) begin
      w_as_nxt = AS_B1;
      // A single 'M' left hanging is the identification reply, not a packet.
      w_ident  = (r_as == AS_B2) && (r_b1 == 7'h4D);
    end
  end

  assign w_dx = {r_b1[1:0], r_b2};
  assign w_dy = {r_b1[3:2], r_byte[5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo   <= '0;
      r_b1    <= 7'd0;
      r_b2    <= 6'd0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_btn   <= 2'd0;
      r_upd   <= 1'b0;
      r_ident <= 1'b0;
    end else begin
      if (r_byte_vld)                          r_tmo <= OW'(TMO);
      else if (r_as != AS_B1 && r_tmo != '0)   r_tmo <= r_tmo - OW'(1);

      if (w_ld1) r_b1 <= r_byte;
      if (w_ld2) r_b2 <= r_byte[5:0];

      r_ident <= w_ident;

      if (w_pub) begin
        r_x   <= w_dx;
        r_y   <= 8'd0 - w_dy;
        r_btn <= {r_b1[4], r_b1[5]};
        r_upd <= ~r_upd;
      end else if (w_pub4) begin
        r_x   <= 8'd0;
        r_y   <= 8'd0;
        r_upd <= ~r_upd;
      end
    end
  end

`ifdef MS_MOUSE_3BTN_EN
  logic r_btn2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_btn2 <= 1'b0;
    else if (w_pub4) r_btn2 <= r_byte[5];
  end
  assign w_btn2 = r_btn2;
`else
  assign w_btn2 = 1'b0;
`endif

  assign bus.ms_x      = r_x;
  assign bus.ms_y      = r_y;
  assign bus.ms_b      = {w_btn2, r_btn};
  assign bus.ms_upd    = r_upd;
  assign bus.ident     = r_ident;
  assign bus.frame_err = r_frame_err;

endmodule
